// File: rtl/eth_pkg.sv
// Shared constants, FSM state types and a saturating counter helper for the Ethernet RX frame controller.
package eth_pkg;

  localparam int FCS_LEN     = 4;
  localparam int MIN_LEN_DEF = 5;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_RECV = 2'd1,
    W_DROP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_SEND  = 2'd2
  } rd_state_t;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_pkt_ram.sv
// Byte-wide simple dual-port packet RAM: one write port, one read port with a registered output.
module eth_pkt_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk_mac,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_dat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_dat
);

  logic [7:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0] rd_dat_q;

  // Write port.
  always_ff @(posedge clk_mac) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  // Registered read; the output register holds its value while rd_en is low and clears on reset.
  always_ff @(posedge clk_mac) begin
    if (!rst_n)     rd_dat_q <= 8'd0;
    else if (rd_en) rd_dat_q <= mem[rd_addr];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// Buffers received frames in a byte ring, commits good frames, rolls back bad ones, and replays
// committed payloads (FCS stripped) on a valid/ready byte stream.
module eth_rx_frame_ctrl
  import eth_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DESC_AW = 3,
  parameter int MIN_LEN = MIN_LEN_DEF
) (
  input  logic        clk_mac,
  input  logic        rst_n,
  input  logic        rx_vld,
  input  logic [7:0]  rx_dat,
  input  logic        rx_sof,
  input  logic        rx_eof,
  input  logic [10:0] rx_len,
  input  logic        rx_err,
  output logic        out_vld,
  output logic [7:0]  out_dat,
  output logic        out_sof,
  output logic        out_eof,
  input  logic        out_rdy,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_drop
);

  localparam int                DESC_DEPTH = 1 << DESC_AW;
  localparam logic [ADDR_W-1:0] USED_LIMIT = {ADDR_W{1'b1}};

  // The receiver's own byte index is not needed; this block keeps its own count.
  logic unused_rx_len;
  assign unused_rx_len = ^rx_len;

  // Write side state
  wr_state_t         w_state_q, w_state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] frame_start_q, frame_start_d;
  logic [11:0]       wcnt_q, wcnt_d;
  logic [15:0]       cnt_ok_q, cnt_ok_d, cnt_drop_q, cnt_drop_d;
  // Read side state
  rd_state_t         r_state_q, r_state_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic [11:0]       rcnt_q, rcnt_d, total_q, total_d, plen_q, plen_d;
  logic              out_vld_q, out_vld_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
  // Descriptor FIFO
  logic [11:0]       desc_mem [0:DESC_DEPTH-1];
  logic [DESC_AW-1:0] desc_wp_q, desc_wp_d, desc_rp_q, desc_rp_d;
  logic [DESC_AW:0]   desc_cnt_q, desc_cnt_d;
  logic              desc_push, desc_pop, desc_full, desc_empty;
  // RAM ports and helpers
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [ADDR_W-1:0] recv_used, sof_ptr, sof_used;
  logic              start_sof;

  assign desc_full  = (desc_cnt_q == (DESC_AW+1)'(DESC_DEPTH));
  assign desc_empty = (desc_cnt_q == '0);
  // Occupancy the ring would have after writing one more byte at wr_ptr.
  assign recv_used  = wr_ptr_q + ADDR_W'(1) - rd_base_q;

  // Write FSM: store bytes, rewind on abort/overflow/error, push a descriptor on a good end.
  always_comb begin
    w_state_d     = w_state_q;
    wr_ptr_d      = wr_ptr_q;
    frame_start_d = frame_start_q;
    wcnt_d        = wcnt_q;
    cnt_ok_d      = cnt_ok_q;
    cnt_drop_d    = cnt_drop_q;
    ram_we        = 1'b0;
    ram_waddr     = wr_ptr_q;
    desc_push     = 1'b0;
    start_sof     = 1'b0;
    sof_ptr       = wr_ptr_q;
    sof_used      = '0;
    if (rx_vld) begin
      case (w_state_q)
        W_IDLE: if (rx_sof && !rx_eof) start_sof = 1'b1;
        W_RECV: begin
          if (rx_eof) begin
            if (rx_err || (wcnt_q < 12'(MIN_LEN))) begin
              wr_ptr_d   = frame_start_q;
              cnt_drop_d = sat_inc16(cnt_drop_q);
            end else begin
              desc_push = 1'b1;
              cnt_ok_d  = sat_inc16(cnt_ok_q);
            end
            w_state_d = W_IDLE;
          end else if (rx_sof) begin
            // Restart: the interrupted frame is dropped and its space reused.
            cnt_drop_d = sat_inc16(cnt_drop_q);
            sof_ptr    = frame_start_q;
            start_sof  = 1'b1;
          end else if (recv_used == USED_LIMIT) begin
            wr_ptr_d  = frame_start_q;
            w_state_d = W_DROP;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            wcnt_d   = wcnt_q + 12'd1;
          end
        end
        W_DROP: if (rx_eof) begin
          cnt_drop_d = sat_inc16(cnt_drop_q);
          w_state_d  = W_IDLE;
        end
        default: w_state_d = W_IDLE;
      endcase
      if (start_sof) begin
        // The first byte gets the same ring-space guard as later bytes.
        sof_used = sof_ptr + ADDR_W'(1) - rd_base_q;
        wr_ptr_d = sof_ptr;
        if (desc_full || (sof_used == USED_LIMIT)) begin
          w_state_d = W_DROP;
        end else begin
          ram_we        = 1'b1;
          ram_waddr     = sof_ptr;
          wr_ptr_d      = sof_ptr + ADDR_W'(1);
          frame_start_d = sof_ptr;
          wcnt_d        = 12'd1;
          w_state_d     = W_RECV;
        end
      end
    end
  end

  // Read FSM: fetch one byte, present it until accepted, release the frame's space at its last byte.
  always_comb begin
    r_state_d = r_state_q;
    rd_base_d = rd_base_q;
    rcnt_d    = rcnt_q;
    total_d   = total_q;
    plen_d    = plen_q;
    out_vld_d = out_vld_q;
    out_sof_d = out_sof_q;
    out_eof_d = out_eof_q;
    ram_re    = 1'b0;
    ram_raddr = rd_base_q + ADDR_W'(rcnt_q);
    desc_pop  = 1'b0;
    case (r_state_q)
      R_IDLE: if (!desc_empty) begin
        total_d   = desc_mem[desc_rp_q];
        plen_d    = desc_mem[desc_rp_q] - 12'(FCS_LEN);
        rcnt_d    = 12'd0;
        r_state_d = R_FETCH;
      end
      R_FETCH: begin
        ram_re    = 1'b1;
        out_vld_d = 1'b1;
        out_sof_d = (rcnt_q == 12'd0);
        out_eof_d = (rcnt_q == plen_q - 12'd1);
        r_state_d = R_SEND;
      end
      R_SEND: if (out_rdy) begin
        out_vld_d = 1'b0;
        out_sof_d = 1'b0;
        out_eof_d = 1'b0;
        if (out_eof_q) begin
          rd_base_d = rd_base_q + ADDR_W'(total_q);
          desc_pop  = 1'b1;
          r_state_d = R_IDLE;
        end else begin
          rcnt_d    = rcnt_q + 12'd1;
          r_state_d = R_FETCH;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Descriptor FIFO pointer/count update; simultaneous push and pop leave the count unchanged.
  always_comb begin
    desc_wp_d  = desc_push ? desc_wp_q + DESC_AW'(1) : desc_wp_q;
    desc_rp_d  = desc_pop  ? desc_rp_q + DESC_AW'(1) : desc_rp_q;
    desc_cnt_d = desc_cnt_q;
    case ({desc_push, desc_pop})
      2'b10:   desc_cnt_d = desc_cnt_q + (DESC_AW+1)'(1);
      2'b01:   desc_cnt_d = desc_cnt_q - (DESC_AW+1)'(1);
      default: desc_cnt_d = desc_cnt_q;
    endcase
  end

  // Descriptor storage holds the stored byte count (FCS included) of each committed frame.
  always_ff @(posedge clk_mac) begin
    if (desc_push) desc_mem[desc_wp_q] <= wcnt_q;
  end

  // State registers for both FSMs, pointers, counters and registered outputs.
  always_ff @(posedge clk_mac) begin
    if (!rst_n) begin
      w_state_q     <= W_IDLE;
      wr_ptr_q      <= '0;
      frame_start_q <= '0;
      wcnt_q        <= '0;
      cnt_ok_q      <= '0;
      cnt_drop_q    <= '0;
      r_state_q     <= R_IDLE;
      rd_base_q     <= '0;
      rcnt_q        <= '0;
      total_q       <= '0;
      plen_q        <= '0;
      out_vld_q     <= 1'b0;
      out_sof_q     <= 1'b0;
      out_eof_q     <= 1'b0;
      desc_wp_q     <= '0;
      desc_rp_q     <= '0;
      desc_cnt_q    <= '0;
    end else begin
      w_state_q     <= w_state_d;
      wr_ptr_q      <= wr_ptr_d;
      frame_start_q <= frame_start_d;
      wcnt_q        <= wcnt_d;
      cnt_ok_q      <= cnt_ok_d;
      cnt_drop_q    <= cnt_drop_d;
      r_state_q     <= r_state_d;
      rd_base_q     <= rd_base_d;
      rcnt_q        <= rcnt_d;
      total_q       <= total_d;
      plen_q        <= plen_d;
      out_vld_q     <= out_vld_d;
      out_sof_q     <= out_sof_d;
      out_eof_q     <= out_eof_d;
      desc_wp_q     <= desc_wp_d;
      desc_rp_q     <= desc_rp_d;
      desc_cnt_q    <= desc_cnt_d;
    end
  end

  eth_pkt_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk_mac (clk_mac),
    .rst_n   (rst_n),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_dat  (rx_dat),
    .rd_en   (ram_re),
    .rd_addr (ram_raddr),
    .rd_dat  (out_dat)
  );

  assign out_vld  = out_vld_q;
  assign out_sof  = out_sof_q;
  assign out_eof  = out_eof_q;
  assign cnt_ok   = cnt_ok_q;
  assign cnt_drop = cnt_drop_q;

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Scoreboard bench for eth_rx_frame_ctrl: directed frames push expected payload bytes into a queue,
// a negedge monitor pops and compares every accepted output byte.
module tb_eth_rx_frame_ctrl;

  logic        clk_mac = 1'b0;
  logic        rst_n   = 1'b0;
  logic        rx_vld  = 1'b0;
  logic [7:0]  rx_dat  = 8'd0;
  logic        rx_sof  = 1'b0;
  logic        rx_eof  = 1'b0;
  logic [10:0] rx_len  = 11'd0;
  logic        rx_err  = 1'b0;
  logic        out_rdy = 1'b0;
  logic        out_vld, out_sof, out_eof;
  logic [7:0]  out_dat;
  logic [15:0] cnt_ok, cnt_drop;

  always #10 clk_mac = ~clk_mac;

  eth_rx_frame_ctrl dut (
    .clk_mac  (clk_mac),
    .rst_n    (rst_n),
    .rx_vld   (rx_vld),
    .rx_dat   (rx_dat),
    .rx_sof   (rx_sof),
    .rx_eof   (rx_eof),
    .rx_len   (rx_len),
    .rx_err   (rx_err),
    .out_vld  (out_vld),
    .out_dat  (out_dat),
    .out_sof  (out_sof),
    .out_eof  (out_eof),
    .out_rdy  (out_rdy),
    .cnt_ok   (cnt_ok),
    .cnt_drop (cnt_drop)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [9:0] sb [$];          // {sof, eof, data}
  logic [9:0] mon_exp;
  int         rdy_mode = 0;     // 0 low, 1 high, 2 random
  int         cyc = 0;
  bit         rate_chk = 1'b0;
  int         mon_n = 0;
  int         mon_sof_cyc = 0;
  int         exp_ok = 0;
  int         exp_drop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(posedge clk_mac) cyc <= cyc + 1;

  // Consumer ready driver.
  always @(posedge clk_mac) begin
    #1;
    case (rdy_mode)
      0:       out_rdy = 1'b0;
      1:       out_rdy = 1'b1;
      default: out_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every byte accepted at the coming edge is checked against the scoreboard head.
  always @(negedge clk_mac) begin
    if (rst_n && out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_unexpected: got byte %02h sof %0b eof %0b, required no output",
                 out_dat, out_sof, out_eof);
      end else begin
        mon_exp = sb.pop_front();
        chk("out_byte{sof,eof,dat}", {22'd0, out_sof, out_eof, out_dat}, {22'd0, mon_exp});
      end
      if (out_sof) begin
        mon_n       = 0;
        mon_sof_cyc = cyc;
      end
      mon_n++;
      if (out_eof && rate_chk) chk("rate_2cyc_per_byte", cyc - mon_sof_cyc, 2 * (mon_n - 1));
    end
  end

  // Drive one frame: n stored bytes (payload + 4 FCS); expected payload pushed when good=1.
  task automatic send_frame(input int n, input logic [7:0] base, input bit err,
                            input bit good, input bit do_eof);
    if (good)
      for (int i = 0; i < n - 4; i++) sb.push_back({i == 0, i == n - 5, 8'(int'(base) + i)});
    for (int i = 0; i < n; i++) begin
      rx_vld = 1'b1; rx_sof = (i == 0); rx_eof = 1'b0; rx_err = 1'b0;
      rx_dat = 8'(int'(base) + i); rx_len = 11'(i);
      @(posedge clk_mac); #1;
    end
    if (do_eof) begin
      rx_vld = 1'b1; rx_sof = 1'b0; rx_eof = 1'b1; rx_err = err; rx_dat = 8'd0;
      @(posedge clk_mac); #1;
    end
    rx_vld = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int k = 0;
    while ((sb.size() != 0 || out_vld) && k < limit) begin
      @(negedge clk_mac);
      k++;
    end
    n_tests++;
    if (sb.size() != 0 || out_vld) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d bytes pending, required 0", sb.size());
    end
    repeat (4) @(negedge clk_mac);
    @(posedge clk_mac); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rx_vld = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0;
    @(posedge clk_mac);
    @(negedge clk_mac);
    chk("reset_out_vld", {31'd0, out_vld}, 32'd0);
    chk("reset_cnt_ok", {16'd0, cnt_ok}, 32'd0);
    chk("reset_cnt_drop", {16'd0, cnt_drop}, 32'd0);
    @(posedge clk_mac); #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_cnt_ok"}, {16'd0, cnt_ok}, exp_ok);
    chk({tag, "_cnt_drop"}, {16'd0, cnt_drop}, exp_drop);
  endtask

  initial begin
    @(posedge clk_mac); #1;
    do_reset();
    chk("reset_out_sof_eof", {30'd0, out_sof, out_eof}, 32'd0);

    // Good 64-byte frame, ready held high, checked at 2 cycles per byte.
    rdy_mode = 1; rate_chk = 1'b1;
    send_frame(64, 8'h00, 1'b0, 1'b1, 1'b1); exp_ok++;
    wait_drain(1000);
    rate_chk = 1'b0;
    chk_cnt("good64");
    chk("good64_rd_base", {20'd0, dut.rd_base_q}, 32'd64);

    // Errored frame rolls back; next good frame reuses its start address.
    send_frame(20, 8'h40, 1'b1, 1'b0, 1'b1); exp_drop++;
    chk("err_rewind_wr_ptr", {20'd0, dut.wr_ptr_q}, 32'd64);
    send_frame(10, 8'h80, 1'b0, 1'b1, 1'b1); exp_ok++;
    wait_drain(1000);
    chk_cnt("err_then_good");

    // Runt (4 bytes) dropped; minimum (5 bytes) gives one byte with sof=eof=1.
    send_frame(4, 8'h90, 1'b0, 1'b0, 1'b1); exp_drop++;
    send_frame(5, 8'hA0, 1'b0, 1'b1, 1'b1); exp_ok++;
    wait_drain(1000);
    chk_cnt("runt");

    // Stray eof and a data beat without sof while idle are ignored.
    rx_vld = 1'b1; rx_eof = 1'b1; @(posedge clk_mac); #1;
    rx_eof = 1'b0; rx_dat = 8'h55; @(posedge clk_mac); #1;
    rx_vld = 1'b0;
    repeat (4) @(posedge clk_mac); #1;
    chk("idle_ignore_wr_ptr", {20'd0, dut.wr_ptr_q}, 32'd79);
    chk_cnt("idle_ignore");

    // A sof mid-frame aborts the partial frame and starts a new one.
    send_frame(6, 8'hB0, 1'b0, 1'b0, 1'b0); exp_drop++;
    send_frame(8, 8'hC0, 1'b0, 1'b1, 1'b1); exp_ok++;
    wait_drain(1000);
    chk_cnt("restart");

    // Nine back-to-back frames with the consumer stalled: eight commit, the ninth is dropped.
    rdy_mode = 0;
    repeat (2) @(posedge clk_mac); #1;
    for (int f = 0; f < 9; f++) send_frame(8, 8'(16 * f), 1'b0, f < 8, 1'b1);
    exp_ok += 8; exp_drop++;
    chk_cnt("fifo_full");
    rdy_mode = 1;
    wait_drain(2000);

    // Ring overflow: first large frame commits, second overflows, third fits after draining.
    rdy_mode = 0;
    repeat (2) @(posedge clk_mac); #1;
    send_frame(2100, 8'h11, 1'b0, 1'b1, 1'b1); exp_ok++;
    send_frame(2100, 8'h22, 1'b0, 1'b0, 1'b1); exp_drop++;
    chk_cnt("overflow");
    rdy_mode = 1;
    wait_drain(10000);
    send_frame(2100, 8'h33, 1'b0, 1'b1, 1'b1); exp_ok++;
    wait_drain(10000);
    chk_cnt("after_overflow");

    // Random consumer backpressure.
    rdy_mode = 2;
    send_frame(30, 8'hD0, 1'b0, 1'b1, 1'b1); exp_ok++;
    wait_drain(2000);
    chk_cnt("backpressure");

    // Reset while a committed frame is presented and another is being received.
    rdy_mode = 0;
    repeat (2) @(posedge clk_mac); #1;
    send_frame(20, 8'hE0, 1'b0, 1'b1, 1'b1);
    send_frame(10, 8'hF0, 1'b0, 1'b0, 1'b0);
    sb.delete();
    do_reset();
    exp_ok = 0; exp_drop = 0;
    rdy_mode = 1;
    send_frame(12, 8'h5A, 1'b0, 1'b1, 1'b1); exp_ok++;
    wait_drain(1000);
    chk_cnt("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
